// File: rtl/mem_initiator.sv
// Valid/ready command initiator for a single-port memory with fixed read latency.
// Optional burst support is enabled by defining MEM_INIT_BURST_EN.
module mem_initiator #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [3:0]            cmd_len,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);

   state_t          state;
   state_t          state_next;
   logic            ready_en;
   logic            accept;
   logic            last_beat;
   logic [3:0]      wait_cnt;

   assign accept = cmd_valid && cmd_ready;

`ifdef MEM_INIT_BURST_EN
   logic [3:0] beats_left;
   assign last_beat = (beats_left == 4'd0);
`else
   logic [3:0] unused_len;
   assign unused_len = cmd_len;
   assign last_beat  = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (accept) state_next = cmd_write ? WR : RD;
         WR:   if (last_beat) state_next = IDLE;
         RD:   state_next = WAIT;
         WAIT: if (wait_cnt == WAIT_LAST) state_next = RESP;
         RESP: if (rsp_ready) state_next = last_beat ? IDLE : RD;
         default: state_next = IDLE;
      endcase
   end

   // ready_en keeps cmd_ready low while reset is applied and for no longer
   always_comb begin
      cmd_ready = (state == IDLE) && ready_en;
      mem_wr_en = (state == WR);
      mem_rd_en = (state == RD);
      rsp_valid = (state == RESP);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ready_en  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_rdata <= '0;
         rsp_addr  <= '0;
         wait_cnt  <= 4'd0;
`ifdef MEM_INIT_BURST_EN
         beats_left <= 4'd0;
`endif
      end else begin
         ready_en <= 1'b1;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mem_addr  <= cmd_addr;
                  mem_wdata <= cmd_wdata;
`ifdef MEM_INIT_BURST_EN
                  beats_left <= cmd_len;
`endif
               end
            end
            WR: begin
               if (!last_beat) begin
                  mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                  mem_wdata <= mem_wdata + DATA_WIDTH'(1);
`ifdef MEM_INIT_BURST_EN
                  beats_left <= beats_left - 4'd1;
`endif
               end
            end
            RD: wait_cnt <= 4'd0;
            WAIT: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (wait_cnt == WAIT_LAST) begin
                  rsp_rdata <= mem_rdata;
                  rsp_addr  <= mem_addr;
               end
            end
            RESP: begin
               // next read beat address advances only once the response is taken
               if (rsp_ready && !last_beat) begin
                  mem_addr <= mem_addr + ADDR_WIDTH'(1);
`ifdef MEM_INIT_BURST_EN
                  beats_left <= beats_left - 4'd1;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator: directed commands against a latency-1 memory model.
// Burst vectors run only when MEM_INIT_BURST_EN is defined.
module tb_mem_initiator;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic [3:0] cmd_len;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_rdata;
   logic [3:0] rsp_addr;
   logic [3:0] mem_addr;
   logic       mem_wr_en, mem_rd_en;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;

   logic [7:0] mem_model [16];

   int checks = 0;
   int fails  = 0;
   logic [11:0] exp_wr [$];
   logic [11:0] exp_rsp [$];

   mem_initiator #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // registered-read memory: data appears the cycle after mem_rd_en
   always @(posedge clk) begin
      if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem_model[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // monitor: pops the scoreboard whenever a write strobe or response handshake is visible
   always @(negedge clk) begin
      logic [11:0] e;
      if (mem_wr_en && mem_rd_en) checkOutput("strobe_overlap", 1, 0);
      if (mem_wr_en === 1'b1) begin
         if (exp_wr.size() == 0) checkOutput("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF);
         else begin
            e = exp_wr.pop_front();
            checkOutput("sb_write", {mem_addr, mem_wdata}, e);
         end
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (exp_rsp.size() == 0) checkOutput("unexpected_rsp", {rsp_addr, rsp_rdata}, 32'hFFFF);
         else begin
            e = exp_rsp.pop_front();
            checkOutput("sb_rsp", {rsp_addr, rsp_rdata}, e);
         end
      end
   end

   // returns after the accepting posedge (+1); the next negedge is cycle T+1
   task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [7:0] data, input logic [3:0] len);
      int n;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_len = len;
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) checkOutput("accept_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drainRsp();
      int n = 0;
      while (exp_rsp.size() != 0 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) checkOutput("rsp_timeout", exp_rsp.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] taddr [3];
      logic [7:0] tdata [3];
      int seen;
      taddr = '{4'h0, 4'hF, 4'h8};
      tdata = '{8'h01, 8'hFF, 8'h80};

      rst = 1'b0; rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 8'h77; cmd_len = 4'd0;

      // reset held with a command pending
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         checkOutput("rst_wr_en", mem_wr_en, 0);
         checkOutput("rst_rd_en", mem_rd_en, 0);
         checkOutput("rst_rsp_valid", rsp_valid, 0);
         checkOutput("rst_cmd_ready", cmd_ready, 0);
      end
      checkOutput("rst_mem_addr", mem_addr, 0);
      rst = 1'b1; cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_cmd_ready", cmd_ready, 1);

      // single write, exact strobe timing
      exp_wr.push_back({4'h3, 8'hA5});
      applyStimulus(1'b1, 4'h3, 8'hA5, 4'd0);
      @(negedge clk);
      checkOutput("wr_strobe", mem_wr_en, 1);
      checkOutput("wr_addr", mem_addr, 4'h3);
      checkOutput("wr_data", mem_wdata, 8'hA5);
      @(negedge clk);
      checkOutput("wr_single", mem_wr_en, 0);
      checkOutput("wr_hold_addr", mem_addr, 4'h3);
      checkOutput("wr_ready_back", cmd_ready, 1);

      // read back: rd_en at T+1, rsp_valid at T+3
      exp_rsp.push_back({4'h3, 8'hA5});
      applyStimulus(1'b0, 4'h3, 8'h00, 4'd0);
      @(negedge clk);
      checkOutput("rd_strobe", mem_rd_en, 1);
      checkOutput("rd_addr", mem_addr, 4'h3);
      @(negedge clk);
      checkOutput("rd_single", mem_rd_en, 0);
      checkOutput("rsp_early", rsp_valid, 0);
      @(negedge clk);
      checkOutput("rsp_latency", rsp_valid, 1);
      @(negedge clk);
      checkOutput("rd_ready_back", cmd_ready, 1);

      // response stall
      exp_wr.push_back({4'h7, 8'h3C});
      applyStimulus(1'b1, 4'h7, 8'h3C, 4'd0);
      @(posedge clk); #1 rsp_ready = 1'b0;
      applyStimulus(1'b0, 4'h7, 8'h00, 4'd0);
      seen = 0;
      while (rsp_valid !== 1'b1 && seen < 20) begin
         seen++;
         @(negedge clk);
      end
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_valid", rsp_valid, 1);
         checkOutput("stall_rdata", rsp_rdata, 8'h3C);
         checkOutput("stall_addr", rsp_addr, 4'h7);
         checkOutput("stall_cmd_ready", cmd_ready, 0);
         checkOutput("stall_strobes", {mem_wr_en, mem_rd_en}, 0);
      end
      exp_rsp.push_back({4'h7, 8'h3C});
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      checkOutput("stall_released", rsp_valid, 0);
      checkOutput("stall_idle", cmd_ready, 1);

      // reset in the cycle after a read strobe
      applyStimulus(1'b0, 4'h3, 8'h00, 4'd0);
      @(negedge clk);
      checkOutput("abort_rd_strobe", mem_rd_en, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready_low", cmd_ready, 0);
      @(posedge clk); #1 rst = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen++;
      end
      checkOutput("abort_no_rsp", seen, 0);
      checkOutput("abort_ready", cmd_ready, 1);
      exp_wr.push_back({4'h9, 8'h5A});
      applyStimulus(1'b1, 4'h9, 8'h5A, 4'd0);
      @(negedge clk);
      checkOutput("abort_next_wr", mem_wr_en, 1);
      exp_rsp.push_back({4'h9, 8'h5A});
      applyStimulus(1'b0, 4'h9, 8'h00, 4'd0);
      drainRsp();

      // boundary addresses and data patterns
      for (int i = 0; i < 3; i++) begin
         exp_wr.push_back({taddr[i], tdata[i]});
         applyStimulus(1'b1, taddr[i], tdata[i], 4'd0);
      end
      for (int i = 0; i < 3; i++) begin
         exp_rsp.push_back({taddr[i], tdata[i]});
         applyStimulus(1'b0, taddr[i], 8'h00, 4'd0);
      end
      drainRsp();

`ifdef MEM_INIT_BURST_EN
      for (int i = 0; i < 4; i++) exp_wr.push_back({4'(4'hE + i), 8'(8'h10 + i)});
      applyStimulus(1'b1, 4'hE, 8'h10, 4'd3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("burst_wr_strobe", mem_wr_en, 1);
         checkOutput("burst_ready_low", cmd_ready, 0);
      end
      @(negedge clk);
      checkOutput("burst_wr_done", mem_wr_en, 0);
      checkOutput("burst_wr_ready", cmd_ready, 1);
      for (int i = 0; i < 4; i++) exp_rsp.push_back({4'(4'hE + i), 8'(8'h10 + i)});
      applyStimulus(1'b0, 4'hE, 8'h00, 4'd3);
      drainRsp();
`else
      // without bursts cmd_len must not produce extra beats
      exp_wr.push_back({4'hC, 8'h42});
      applyStimulus(1'b1, 4'hC, 8'h42, 4'd3);
      @(negedge clk);
      checkOutput("len_ignored_wr", mem_wr_en, 1);
      @(negedge clk);
      checkOutput("len_ignored_single", mem_wr_en, 0);
`endif

      repeat (5) @(negedge clk);
      checkOutput("wr_queue_empty", exp_wr.size(), 0);
      checkOutput("rsp_queue_empty", exp_rsp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
